// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types and constants for the 7-segment scan driver
//   seg7_state_t : scan FSM states (GAP = dark slot prefix, DRIVE = digit lit)
//   SEG_OFF      : all segments dark (active-low)
//   AN_OFF       : all digit enables off (active-low)
//   HEX7_TABLE   : hex nibble -> active-high segments, bit 0 = a .. bit 6 = g
package seg7_pkg;

    typedef enum logic {
        GAP   = 1'b0,
        DRIVE = 1'b1
    } seg7_state_t;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [3:0] AN_OFF  = 4'hF;

    localparam logic [6:0] HEX7_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - combinational hex nibble to 7-segment decoder
//   i_nibble : 4-bit hex value
//   o_seg    : active-high segments, o_seg[0] = a .. o_seg[6] = g
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = HEX7_TABLE[i_nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - 4-digit multiplexed 7-segment scan driver with anti-ghost gap
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   load       : one-cycle strobe capturing data/dp_in/blank_in into the pending register
//   data       : four hex digits, data[3:0] is the rightmost digit (an[0])
//   dp_in      : per-digit decimal point, 1 = lit
//   blank_in   : per-digit blank, 1 = dark
//   seg        : active-low segments {dp, g..a}, registered
//   an         : active-low digit enables, at most one low, registered
//   frame_done : one-cycle pulse on the last drive cycle of digit 3, registered
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV   = 50000,
    parameter int GAP_CYCLES = 500
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] data,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_in,
    output logic [7:0]  seg,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] DRV_LAST = CW'(SCAN_DIV - GAP_CYCLES - 1);

    seg7_state_t r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;

    logic [15:0] r_pend_data;
    logic [3:0]  r_pend_dp;
    logic [3:0]  r_pend_blank;
    logic [15:0] r_act_data;
    logic [3:0]  r_act_dp;
    logic [3:0]  r_act_blank;

    logic [7:0]  r_seg;
    logic [3:0]  r_an;
    logic        r_frame_done;

    seg7_state_t w_state_next;
    logic [CW-1:0] w_cnt_next;
    logic [1:0]    w_idx_next;
    logic          w_copy;
    logic [15:0]   w_act_data_next;
    logic [3:0]    w_act_dp_next;
    logic [3:0]    w_act_blank_next;
    logic [3:0]    w_nibble;
    logic [6:0]    w_hex;
    logic [7:0]    w_seg_next;
    logic [3:0]    w_an_next;
    logic          w_frame_done_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= GAP;
            r_cnt   <= '0;
            r_idx   <= 2'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
        end
    end

    // Next-state, slot counter and digit index; w_copy marks the frame boundary
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + CW'(1);
        w_idx_next   = r_idx;
        w_copy       = 1'b0;
        case (r_state)
            GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_cnt_next   = '0;
                    w_state_next = DRIVE;
                    w_copy       = (r_idx == 2'd0);
                end
            end
            DRIVE: begin
                if (r_cnt == DRV_LAST) begin
                    w_cnt_next   = '0;
                    w_state_next = GAP;
                    w_idx_next   = r_idx + 2'd1;
                end
            end
            default: begin
                w_cnt_next   = '0;
                w_state_next = GAP;
            end
        endcase
    end

    // Outputs are computed from the post-edge state so the registered seg/an
    // line up with the state they describe, including the freshly copied frame.
    assign w_act_data_next  = w_copy ? r_pend_data  : r_act_data;
    assign w_act_dp_next    = w_copy ? r_pend_dp    : r_act_dp;
    assign w_act_blank_next = w_copy ? r_pend_blank : r_act_blank;
    assign w_nibble         = w_act_data_next[{w_idx_next, 2'b00} +: 4];

    seg7_hex_decode u_hex_decode (
        .i_nibble (w_nibble),
        .o_seg    (w_hex)
    );

    always_comb begin
        w_seg_next        = SEG_OFF;
        w_an_next         = AN_OFF;
        w_frame_done_next = 1'b0;
        if (w_state_next == DRIVE) begin
            if (!w_act_blank_next[w_idx_next]) begin
                w_an_next  = ~(4'b0001 << w_idx_next);
                w_seg_next = {~w_act_dp_next[w_idx_next], ~w_hex};
            end
            w_frame_done_next = (w_cnt_next == DRV_LAST) && (w_idx_next == 2'd3);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_data  <= 16'h0000;
            r_pend_dp    <= 4'h0;
            r_pend_blank <= 4'hF;
            r_act_data   <= 16'h0000;
            r_act_dp     <= 4'h0;
            r_act_blank  <= 4'hF;
            r_seg        <= SEG_OFF;
            r_an         <= AN_OFF;
            r_frame_done <= 1'b0;
        end else begin
            if (load) begin
                r_pend_data  <= data;
                r_pend_dp    <= dp_in;
                r_pend_blank <= blank_in;
            end
            // Copy uses the pre-edge pending value, so a coincident load waits a frame
            if (w_copy) begin
                r_act_data  <= r_pend_data;
                r_act_dp    <= r_pend_dp;
                r_act_blank <= r_pend_blank;
            end
            r_seg        <= w_seg_next;
            r_an         <= w_an_next;
            r_frame_done <= w_frame_done_next;
        end
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign frame_done = r_frame_done;

endmodule
